mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/mem_lat_counter.sv | 41 ++++
 rtl/mem_responder.sv | 159 +++++++++++++++
 tb/tb_mem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the mem_responder slice:
//   - state_t   : responder FSM encoding (also exported on the debug port)
//   - WEB_NONE  : active-low byte-enable value meaning "no write"
//   - LAT_MIN / LAT_MAX : legal range of the LATENCY parameter
//   - CNT_W     : width of the wait counter, wide enough for LAT_MAX-1
// ---------------------------------------------------------------------------
package mem_resp_pkg;

  localparam int          LAT_MIN  = 2;
  localparam int          LAT_MAX  = 15;
  localparam int          CNT_W    = 4;
  localparam logic [3:0]  WEB_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_R_WAIT = 2'd1,
    ST_R_DONE = 2'd2,
    ST_W_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/mem_lat_counter.sv
// ---------------------------------------------------------------------------
// mem_lat_counter
// Down-counter used to time SRAM wait cycles.
// Ports:
//   clk, rst     : clock and synchronous active-high reset (count -> 0)
//   i_load       : load i_load_val (has priority over decrement)
//   i_load_val   : value to load
//   i_dec        : decrement by one; saturates at zero
//   o_cnt        : current count
//   o_zero       : high when the count is zero
// ---------------------------------------------------------------------------
module mem_lat_counter
  import mem_resp_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Bridges a stalling CPU data port onto a synchronous SRAM with a fixed
// number of wait cycles per access.
//
// Handshake: the CPU raises OE (read) or any WEB bit low (write) and must
// hold the request unchanged while Stall is high. A read completes with a
// one-cycle rDone strobe, DO valid from that cycle on; a write completes
// when Stall drops. Requests presented during the rDone cycle are not
// accepted until the following cycle.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   OE, WEB, A, DI  : CPU read request, byte write enables (active low),
//                     byte address, write data
//   DO, Stall, rDone: read data, CPU freeze, read-complete strobe
//   SRAM_*          : SRAM select, read enable, byte write enables,
//                     word address, write data, read data
//   o_dbg_state     : current FSM state for observation
// ---------------------------------------------------------------------------
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              OE,
  input  logic [3:0]        WEB,
  input  logic [31:0]       A,
  input  logic [31:0]       DI,
  output logic [31:0]       DO,
  output logic              Stall,
  output logic              rDone,
  output logic              SRAM_CS,
  output logic              SRAM_OE,
  output logic [3:0]        SRAM_WEB,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [31:0]       SRAM_DI,
  input  logic [31:0]       SRAM_DO,
  output state_t            o_dbg_state
);

  generate
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
      $error("mem_responder: LATENCY out of range");
    end
  endgenerate

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_web;
  logic [31:0]       r_di;
  logic [31:0]       r_do;
  // Marks the first W_WAIT cycle so the SRAM sees exactly one write strobe.
  logic              r_first;

  logic              w_write;
  logic              w_req;
  logic              w_load;
  logic              w_dec;
  logic              w_capture;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_zero;

  // Byte offset and high address bits are intentionally dropped (aliasing).
  logic              w_unused_addr;
  assign w_unused_addr = ^{A[31:ADDR_W+2], A[1:0], w_cnt};

  assign w_write = (WEB != WEB_NONE);
  assign w_req   = OE | w_write;

  mem_lat_counter #(
    .W(CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (CNT_W'(LATENCY - 1)),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_dec     = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_load = 1'b1;
          // A write wins over a simultaneous read; the read is dropped.
          w_next = w_write ? ST_W_WAIT : ST_R_WAIT;
        end
      end
      ST_R_WAIT: begin
        if (w_zero) begin
          w_capture = 1'b1;
          w_next    = ST_R_DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_R_DONE: begin
        w_next = ST_IDLE;
      end
      ST_W_WAIT: begin
        if (w_zero) begin
          w_next = ST_IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_web   <= '0;
      r_di    <= '0;
      r_do    <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= w_load & w_write;
      if (w_load) begin
        r_addr <= A[ADDR_W+1:2];
        r_web  <= WEB;
        r_di   <= DI;
      end
      if (w_capture) begin
        r_do <= SRAM_DO;
      end
    end
  end

  // Stall's IDLE term is combinational so the CPU freezes in the request cycle.
  assign Stall    = ((r_state == ST_IDLE) && w_req) ||
                    (r_state == ST_R_WAIT) || (r_state == ST_W_WAIT);
  assign rDone    = (r_state == ST_R_DONE);
  assign SRAM_CS  = (r_state == ST_R_WAIT) || (r_state == ST_W_WAIT);
  assign SRAM_OE  = (r_state == ST_R_WAIT);
  assign SRAM_WEB = ((r_state == ST_W_WAIT) && r_first) ? r_web : WEB_NONE;
  assign SRAM_A   = r_addr;
  assign SRAM_DI  = r_di;
  assign DO       = r_do;

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder (LATENCY=2) with a behavioural
// synchronous SRAM. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int LATENCY = 2;
  localparam int ADDR_W  = 14;

  logic              clk;
  logic              rst;
  logic              OE;
  logic [3:0]        WEB;
  logic [31:0]       A;
  logic [31:0]       DI;
  logic [31:0]       DO;
  logic              Stall;
  logic              rDone;
  logic              SRAM_CS;
  logic              SRAM_OE;
  logic [3:0]        SRAM_WEB;
  logic [ADDR_W-1:0] SRAM_A;
  logic [31:0]       SRAM_DI;
  logic [31:0]       SRAM_DO;
  state_t            dbg_state;

  logic              preload;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_do;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  mem_responder #(
    .LATENCY (LATENCY),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .OE          (OE),
    .WEB         (WEB),
    .A           (A),
    .DI          (DI),
    .DO          (DO),
    .Stall       (Stall),
    .rDone       (rDone),
    .SRAM_CS     (SRAM_CS),
    .SRAM_OE     (SRAM_OE),
    .SRAM_WEB    (SRAM_WEB),
    .SRAM_A      (SRAM_A),
    .SRAM_DI     (SRAM_DI),
    .SRAM_DO     (SRAM_DO),
    .o_dbg_state (dbg_state)
  );

  // ---------------- synchronous SRAM model ----------------
  always @(posedge clk) begin
    if (preload) begin
      mem[14'h040] <= 32'hDEADBEEF;
      mem[14'h041] <= 32'hAAAAAAAA;
      mem[14'h042] <= 32'h55555555;
    end else if (SRAM_CS) begin
      if (SRAM_OE) SRAM_DO <= mem[SRAM_A];
      for (int b = 0; b < 4; b++) begin
        if (!SRAM_WEB[b]) mem[SRAM_A][8*b +: 8] <= SRAM_DI[8*b +: 8];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Read of byte address a; request held through the wait cycles.
  task automatic do_read(input logic [31:0] a, input logic [31:0] data);
    logic [ADDR_W-1:0] wa;
    wa  = a[ADDR_W+1:2];
    OE  = 1'b1;
    WEB = WEB_NONE;
    A   = a;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) OE = 1'b0;
      @(negedge clk);
      check("rd_stall", 32'(Stall), 32'(c <= 2));
      check("rd_done",  32'(rDone), 32'(c == 3));
      if (c == 1) begin
        check("rd_cs",   32'(SRAM_CS),  32'd1);
        check("rd_oe",   32'(SRAM_OE),  32'd1);
        check("rd_web",  32'(SRAM_WEB), 32'hF);
        check("rd_addr", 32'(SRAM_A),   32'(wa));
      end
      if (c == 3) check("rd_data", DO, data);
      next_cycle();
    end
    exp_do = data;
    @(negedge clk);
    check("rd_after_done", 32'(rDone), 32'd0);
    check("rd_after_cs",   32'(SRAM_CS), 32'd0);
    check("rd_after_do",   DO, exp_do);
    next_cycle();
  endtask

  // Write (optionally with OE also raised); DO must not move.
  task automatic do_write(input logic [31:0] a, input logic [3:0] web,
                          input logic [31:0] di, input logic oe);
    logic [ADDR_W-1:0] wa;
    wa  = a[ADDR_W+1:2];
    OE  = oe;
    WEB = web;
    A   = a;
    DI  = di;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        OE  = 1'b0;
        WEB = WEB_NONE;
      end
      @(negedge clk);
      check("wr_stall", 32'(Stall), 32'(c <= 2));
      check("wr_done",  32'(rDone), 32'd0);
      check("wr_web",   32'(SRAM_WEB), (c == 1) ? 32'(web) : 32'hF);
      if (c == 1 || c == 2) begin
        check("wr_cs",   32'(SRAM_CS), 32'd1);
        check("wr_oe",   32'(SRAM_OE), 32'd0);
        check("wr_di",   SRAM_DI, di);
        check("wr_addr", 32'(SRAM_A), 32'(wa));
      end
      check("wr_do_hold", DO, exp_do);
      next_cycle();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t1;
    int t2;
    n_tests = 0;
    n_fail  = 0;
    exp_do  = 32'h0;
    rst     = 1'b1;
    preload = 1'b1;
    OE      = 1'b0;
    WEB     = WEB_NONE;
    A       = 32'h0;
    DI      = 32'h0;

    // Reset behaviour, including combinational Stall from IDLE during reset.
    next_cycle();
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_do",    DO, 32'h0);
    check("rst_done",  32'(rDone), 32'd0);
    check("rst_cs",    32'(SRAM_CS), 32'd0);
    check("rst_oe",    32'(SRAM_OE), 32'd0);
    check("rst_web",   32'(SRAM_WEB), 32'hF);
    check("rst_stall", 32'(Stall), 32'd0);
    next_cycle();
    OE = 1'b1;
    @(negedge clk);
    check("rst_stall_req", 32'(Stall), 32'd1);
    check("rst_done_req",  32'(rDone), 32'd0);
    next_cycle();
    OE      = 1'b0;
    rst     = 1'b0;
    preload = 1'b0;
    next_cycle();

    // Plain read of word 0x40.
    do_read(32'h0000_0100, 32'hDEADBEEF);

    // Partial write of the low half of word 0x41, then read it back.
    do_write(32'h0000_0104, 4'b1100, 32'h11223344, 1'b0);
    do_read(32'h0000_0104, 32'hAAAA3344);

    // Read and write requested together: the write wins, DO untouched.
    do_write(32'h0000_0108, 4'b0000, 32'hCAFEF00D, 1'b1);
    do_read(32'h0000_0108, 32'hCAFEF00D);

    // Address aliasing: high bits and byte offset ignored -> word 0x40.
    do_read(32'h0001_0103, 32'hDEADBEEF);

    // Back-to-back reads with OE held through the rDone cycle.
    t1  = -1;
    t2  = -1;
    OE  = 1'b1;
    WEB = WEB_NONE;
    A   = 32'h0000_0100;
    for (int c = 0; c < 20 && t2 < 0; c++) begin
      @(negedge clk);
      if (rDone) begin
        if (t1 < 0) begin
          t1 = c;
          check("b2b_data1", DO, 32'hDEADBEEF);
          A = 32'h0000_0104;
        end else begin
          t2 = c;
          check("b2b_data2", DO, 32'hAAAA3344);
          OE = 1'b0;
        end
      end
      next_cycle();
    end
    OE = 1'b0;
    exp_do = 32'hAAAA3344;
    check("b2b_first_at", 32'(t1), 32'd3);
    check("b2b_gap",      32'(t2 - t1), 32'd4);

    // Reset during R_WAIT aborts the read.
    OE = 1'b1;
    A  = 32'h0000_0100;
    @(negedge clk);
    check("abort_stall_t", 32'(Stall), 32'd1);
    next_cycle();
    rst = 1'b1;
    OE  = 1'b0;
    @(negedge clk);
    check("abort_rwait", 32'(dbg_state), 32'(ST_R_WAIT));
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_done",  32'(rDone), 32'd0);
      check("abort_do",    DO, 32'h0);
      check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
      check("abort_stall", 32'(Stall), 32'd0);
      check("abort_cs",    32'(SRAM_CS), 32'd0);
      next_cycle();
    end
    exp_do = 32'h0;

    // Data written before the abort is still readable afterwards.
    do_read(32'h0000_0108, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
